fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Owns the 32-bit PC and drives the instruction-memory address.
- Assembles two-word (LDM) instructions into one instruction + immediate pair and presents registered instruction, immediate and return PC to decode.
- Applies redirects (branch, pop PC, interrupt) chosen by the control unit.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, control-unit redirect inputs and
// the IF/ID register outputs presented to decode.
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 16
);
  logic              fetch_pc_enable;
  logic              flush;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] pc_jmp;
  logic [ADDR_W-1:0] pc_pop;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic [INST_W-1:0] instruction;
  logic [INST_W-1:0] imm;
  logic [ADDR_W-1:0] pc_next_out;
  logic              if_valid;

  modport master (
    input  fetch_pc_enable, flush, pc_sel, pc_jmp, pc_pop, imem_data,
    output imem_addr, instruction, imm, pc_next_out, if_valid
  );

  modport slave (
    output fetch_pc_enable, flush, pc_sel, pc_jmp, pc_pop, imem_data,
    input  imem_addr, instruction, imm, pc_next_out, if_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with two-word LDM assembly and redirects.
// Optional IMEM_BOOT_VECTOR_EN: load the start PC from imem words 0/1 after reset.
module fetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 16,
  parameter logic [4:0]        LDM_OPCODE = 5'b11000,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0020,
  parameter logic [ADDR_W-1:0] INT_VECTOR = 32'h0000_0002
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN, IMM} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_sel_val;
  logic [INST_W-1:0] hold_word;
  logic              is_ldm;
`ifdef IMEM_BOOT_VECTOR_EN
  logic [ADDR_W-INST_W-1:0] pc_hi;
`endif

  assign bus.imem_addr = pc;
  assign pc_inc        = pc + 1'b1;
  assign is_ldm        = (bus.imem_data[INST_W-1 -: 5] == LDM_OPCODE);

  always_comb begin
    pc_sel_val = pc_inc;
    case (bus.pc_sel)
      2'd0: pc_sel_val = pc_inc;
      2'd1: pc_sel_val = bus.pc_jmp;
      2'd2: pc_sel_val = bus.pc_pop;
      2'd3: pc_sel_val = INT_VECTOR;
      default: pc_sel_val = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.instruction <= '0;
      bus.imm         <= '0;
      bus.pc_next_out <= '0;
      bus.if_valid    <= 1'b0;
      hold_word       <= '0;
`ifdef IMEM_BOOT_VECTOR_EN
      pc_hi           <= '0;
      pc              <= '0;
      state           <= BOOT_HI;
`else
      pc              <= RESET_PC;
      state           <= RUN;
`endif
    end else begin
      case (state)
`ifdef IMEM_BOOT_VECTOR_EN
        // Boot runs to completion regardless of flush/stall.
        BOOT_HI: begin
          pc_hi <= bus.imem_data[ADDR_W-INST_W-1:0];
          pc    <= {{(ADDR_W-1){1'b0}}, 1'b1};
          state <= BOOT_LO;
        end
        BOOT_LO: begin
          pc    <= {pc_hi, bus.imem_data};
          state <= RUN;
        end
`endif
        RUN, IMM: begin
          if (bus.flush) begin
            pc              <= pc_sel_val;
            bus.instruction <= '0;
            bus.imm         <= '0;
            bus.if_valid    <= 1'b0;
            state           <= RUN;
          end else if (bus.fetch_pc_enable) begin
            if (state == IMM) begin
              bus.instruction <= hold_word;
              bus.imm         <= bus.imem_data;
              bus.pc_next_out <= pc_inc;
              bus.if_valid    <= 1'b1;
              pc              <= pc_sel_val;
              state           <= RUN;
            end else if (is_ldm) begin
              // First LDM word: park it and fetch the immediate next.
              hold_word       <= bus.imem_data;
              pc              <= pc_inc;
              bus.instruction <= '0;
              bus.imm         <= '0;
              bus.if_valid    <= 1'b0;
              state           <= IMM;
            end else begin
              bus.instruction <= bus.imem_data;
              bus.imm         <= '0;
              bus.pc_next_out <= pc_inc;
              bus.if_valid    <= 1'b1;
              pc              <= pc_sel_val;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot/reset, sequential fetch, LDM, stall,
// flush and redirect sources, PC wrap, reset during LDM.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef IMEM_BOOT_VECTOR_EN
  localparam logic [31:0] BASE = 32'h40;
`else
  localparam logic [31:0] BASE = 32'h20;
`endif

  logic [15:0] mem [0:255];

  fetch_stage_if #(.ADDR_W(32), .INST_W(16)) bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = (bus.imem_addr[31:8] == 24'd0) ? mem[bus.imem_addr[7:0]] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] im,
                          input logic [31:0] pcn, input logic v, input logic [31:0] addr);
    chk({tag, ".instruction"}, {16'h0, bus.instruction}, {16'h0, ins});
    chk({tag, ".imm"},         {16'h0, bus.imm},         {16'h0, im});
    chk({tag, ".pc_next_out"}, bus.pc_next_out,          pcn);
    chk({tag, ".if_valid"},    {31'h0, bus.if_valid},    {31'h0, v});
    chk({tag, ".imem_addr"},   bus.imem_addr,            addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0800;
`ifdef IMEM_BOOT_VECTOR_EN
    mem[0] = 16'h0000;
    mem[1] = 16'h0040;
`endif
    mem[BASE[7:0]+8'd0] = 16'h1001;
    mem[BASE[7:0]+8'd1] = 16'h1002;
    mem[BASE[7:0]+8'd2] = 16'h1003;
    mem[BASE[7:0]+8'd3] = 16'hC100;
    mem[BASE[7:0]+8'd4] = 16'h1234;
    mem[BASE[7:0]+8'd5] = 16'hC0AA;
    mem[BASE[7:0]+8'd6] = 16'h5555;
    mem[BASE[7:0]+8'd7] = 16'h2007;
    mem[BASE[7:0]+8'd8] = 16'hC0BB;
    mem[BASE[7:0]+8'd9] = 16'h7777;
    mem[8'h80] = 16'h3001;
    mem[8'h90] = 16'h4000;
    mem[8'h91] = 16'hC0CC;
    mem[8'h92] = 16'h1111;

    bus.fetch_pc_enable = 1'b1;
    bus.flush  = 1'b0;
    bus.pc_sel = 2'd0;
    bus.pc_jmp = 32'h0;
    bus.pc_pop = 32'h0;
    rst = 1'b0;
    step(); step();
`ifdef IMEM_BOOT_VECTOR_EN
    chk_ifid("reset", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    chk_ifid("boot_hi", 16'h0, 16'h0, 32'h0, 1'b0, 32'h1);
    step();
    chk_ifid("boot_lo", 16'h0, 16'h0, 32'h0, 1'b0, BASE);
`else
    chk_ifid("reset", 16'h0, 16'h0, 32'h0, 1'b0, BASE);
    rst = 1'b1;
`endif

    // Sequential fetch, one cycle behind the address
    step(); chk_ifid("seq0", 16'h1001, 16'h0, BASE+1, 1'b1, BASE+1);
    step(); chk_ifid("seq1", 16'h1002, 16'h0, BASE+2, 1'b1, BASE+2);
    step(); chk_ifid("seq2", 16'h1003, 16'h0, BASE+3, 1'b1, BASE+3);

    // LDM: bubble then the pair
    step(); chk_ifid("ldm_bub", 16'h0, 16'h0, BASE+3, 1'b0, BASE+4);
    step(); chk_ifid("ldm", 16'hC100, 16'h1234, BASE+5, 1'b1, BASE+5);

    // Stall while in IMM
    step(); chk_ifid("ldm2_bub", 16'h0, 16'h0, BASE+5, 1'b0, BASE+6);
    bus.fetch_pc_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_ifid("stall_imm", 16'h0, 16'h0, BASE+5, 1'b0, BASE+6);
    end
    bus.fetch_pc_enable = 1'b1;
    step(); chk_ifid("ldm2", 16'hC0AA, 16'h5555, BASE+7, 1'b1, BASE+7);
    step(); chk_ifid("after_ldm2", 16'h2007, 16'h0, BASE+8, 1'b1, BASE+8);

    // Stall in RUN holds a valid instruction
    bus.fetch_pc_enable = 1'b0;
    step(); chk_ifid("stall_run", 16'h2007, 16'h0, BASE+8, 1'b1, BASE+8);
    bus.fetch_pc_enable = 1'b1;

    // Flush from IMM discards the pending LDM
    step(); chk_ifid("ldm3_bub", 16'h0, 16'h0, BASE+8, 1'b0, BASE+9);
    bus.flush = 1'b1; bus.pc_sel = 2'd1; bus.pc_jmp = 32'h80;
    step(); chk_ifid("flush_imm", 16'h0, 16'h0, BASE+8, 1'b0, 32'h80);
    bus.flush = 1'b0; bus.pc_sel = 2'd0;
    step(); chk_ifid("post_flush", 16'h3001, 16'h0, 32'h81, 1'b1, 32'h81);

    // Flush during stall still redirects (pop source)
    bus.fetch_pc_enable = 1'b0; bus.flush = 1'b1; bus.pc_sel = 2'd2; bus.pc_pop = 32'h1234_5678;
    step(); chk_ifid("flush_pop", 16'h0, 16'h0, 32'h81, 1'b0, 32'h1234_5678);

    // Normal fetch with interrupt vector as next PC
    bus.fetch_pc_enable = 1'b1; bus.flush = 1'b0; bus.pc_sel = 2'd3;
    step(); chk_ifid("int_vec", 16'h0, 16'h0, 32'h1234_5679, 1'b1, 32'h2);

    // PC wrap
    bus.flush = 1'b1; bus.pc_sel = 2'd1; bus.pc_jmp = 32'hFFFF_FFFF;
    step(); chk("wrap_setup", bus.imem_addr, 32'hFFFF_FFFF);
    bus.flush = 1'b0; bus.pc_sel = 2'd0;
    step(); chk_ifid("wrap", 16'h0, 16'h0, 32'h0, 1'b1, 32'h0);

    // Reset in the middle of an LDM
    bus.flush = 1'b1; bus.pc_sel = 2'd1; bus.pc_jmp = 32'h90;
    step();
    bus.flush = 1'b0; bus.pc_sel = 2'd0;
    step(); chk_ifid("pre_rst", 16'h4000, 16'h0, 32'h91, 1'b1, 32'h91);
    step(); chk_ifid("pre_rst_bub", 16'h0, 16'h0, 32'h91, 1'b0, 32'h92);
    rst = 1'b0;
    step();
`ifdef IMEM_BOOT_VECTOR_EN
    chk_ifid("mid_rst", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    step(); step();
`else
    chk_ifid("mid_rst", 16'h0, 16'h0, 32'h0, 1'b0, BASE);
    rst = 1'b1;
`endif
    step(); chk_ifid("post_rst", 16'h1001, 16'h0, BASE+1, 1'b1, BASE+1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
